// File: rtl/uv_iob_filt.sv
// ---------------------------------------------------------------------------
// uv_iob_filt
//
// GPIO pad bridge with a clocked input path. Each pad is resolved to a clean
// logic level, synchronised into clk, optionally glitch-filtered and turned
// into per-pin rise/fall pulses. The output side supports push-pull and
// open-drain drive.
//
// Parameters:
//   IO_NUM      - number of GPIO channels
//   SYNC_STAGES - synchroniser depth (>= 2)
//   FILT_W      - glitch-filter counter width
//
// Ports:
//   clk          in     block clock
//   rst_n        in     asynchronous active-low reset
//   io_gpio      inout  pads
//   gpio_pu      in     pull-up select, used when input is disabled
//   gpio_pd      in     pull-down select, used when input is disabled
//   gpio_ie      in     input enable
//   gpio_oe      in     output enable
//   gpio_out     in     output data
//   gpio_od      in     open-drain mode
//   filt_en      in     per-pin glitch filter enable
//   filt_thresh  in     extra stable cycles before the filtered level flips
//   gpio_in      out    synchronised and filtered level
//   gpio_rise    out    one-cycle pulse on a 0->1 change of gpio_in
//   gpio_fall    out    one-cycle pulse on a 1->0 change of gpio_in
//
// Build option:
//   IOB_EDGE_DET_EN - when defined, the edge pulse registers are built;
//                     otherwise gpio_rise/gpio_fall are tied to 0.
// ---------------------------------------------------------------------------
module uv_iob_filt #(
    parameter int unsigned IO_NUM      = 32,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_W      = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    inout  wire  [IO_NUM-1:0]   io_gpio,
    input  logic [IO_NUM-1:0]   gpio_pu,
    input  logic [IO_NUM-1:0]   gpio_pd,
    input  logic [IO_NUM-1:0]   gpio_ie,
    input  logic [IO_NUM-1:0]   gpio_oe,
    input  logic [IO_NUM-1:0]   gpio_out,
    input  logic [IO_NUM-1:0]   gpio_od,
    input  logic [IO_NUM-1:0]   filt_en,
    input  logic [FILT_W-1:0]   filt_thresh,
    output logic [IO_NUM-1:0]   gpio_in,
    output logic [IO_NUM-1:0]   gpio_rise,
    output logic [IO_NUM-1:0]   gpio_fall
);

    // Resolved pad level, never Z.
    logic [IO_NUM-1:0]             raw;
    // All synchroniser stages packed side by side; stage 0 in the low slice.
    logic [SYNC_STAGES*IO_NUM-1:0] sync_q;
    logic [IO_NUM-1:0]             sync_last;

    // -----------------------------------------------------------------------
    // Synchroniser chain
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[(SYNC_STAGES-1)*IO_NUM-1:0], raw};
        end
    end

    assign sync_last = sync_q[SYNC_STAGES*IO_NUM-1 -: IO_NUM];

    // -----------------------------------------------------------------------
    // Per-pin pad drive, input resolution, filter and edge detection
    // -----------------------------------------------------------------------
    for (genvar gi = 0; gi < IO_NUM; gi++) begin : g_pin
        logic              state_q;
        logic              state_d;
        logic [FILT_W-1:0] cnt_q;
        logic [FILT_W-1:0] cnt_d;

        // Open-drain with out=1 releases the pad; otherwise drive out.
        assign io_gpio[gi] = (gpio_oe[gi] && !(gpio_od[gi] && gpio_out[gi]))
                             ? gpio_out[gi] : 1'bz;

        assign raw[gi] = gpio_ie[gi] ? io_gpio[gi] :
                         gpio_pu[gi] ? 1'b1 :
                         gpio_pd[gi] ? 1'b0 : 1'b0;

        // cnt stops at filt_thresh because the >= test flips state there,
        // so it cannot wrap even at the maximum threshold.
        always_comb begin
            state_d = state_q;
            cnt_d   = '0;
            if (!filt_en[gi]) begin
                state_d = sync_last[gi];
            end else if (sync_last[gi] != state_q) begin
                if (cnt_q >= filt_thresh) begin
                    state_d = sync_last[gi];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= 1'b0;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        assign gpio_in[gi] = state_q;

`ifdef IOB_EDGE_DET_EN
        logic rise_q;
        logic fall_q;

        // Built from the next state so the pulse lines up with gpio_in.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rise_q <= 1'b0;
                fall_q <= 1'b0;
            end else begin
                rise_q <= state_d & ~state_q;
                fall_q <= ~state_d & state_q;
            end
        end

        assign gpio_rise[gi] = rise_q;
        assign gpio_fall[gi] = fall_q;
`endif
    end

`ifndef IOB_EDGE_DET_EN
    assign gpio_rise = '0;
    assign gpio_fall = '0;
`endif

endmodule

// File: tb/tb_uv_iob_filt.sv
module tb_uv_iob_filt;

    localparam int unsigned N = 4;

`ifdef IOB_EDGE_DET_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    wire  [N-1:0] io_gpio;
    logic [N-1:0] gpio_pu, gpio_pd, gpio_ie, gpio_oe, gpio_out, gpio_od;
    logic [N-1:0] filt_en;
    logic [3:0]   filt_thresh;
    logic [N-1:0] gpio_in, gpio_rise, gpio_fall;

    // Bench-side pad drivers and weak pull-up
    logic [N-1:0] tb_en;
    logic [N-1:0] tb_val;

    pullup (io_gpio);

    for (genvar g = 0; g < N; g++) begin : g_drv
        assign io_gpio[g] = tb_en[g] ? tb_val[g] : 1'bz;
    end

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    uv_iob_filt #(
        .IO_NUM      (N),
        .SYNC_STAGES (2),
        .FILT_W      (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .io_gpio     (io_gpio),
        .gpio_pu     (gpio_pu),
        .gpio_pd     (gpio_pd),
        .gpio_ie     (gpio_ie),
        .gpio_oe     (gpio_oe),
        .gpio_out    (gpio_out),
        .gpio_od     (gpio_od),
        .filt_en     (filt_en),
        .filt_thresh (filt_thresh),
        .gpio_in     (gpio_in),
        .gpio_rise   (gpio_rise),
        .gpio_fall   (gpio_fall)
    );

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] ep(input logic [N-1:0] v);
        return EDGE ? v : '0;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [N-1:0] acc_in, acc_p;

    initial begin
        rst_n       = 1'b0;
        gpio_pu     = '0;
        gpio_pd     = '0;
        gpio_ie     = '1;
        gpio_oe     = '0;
        gpio_out    = '0;
        gpio_od     = '0;
        filt_en     = '0;
        filt_thresh = 4'd0;
        tb_en       = '0;
        tb_val      = '0;

        // Reset with pads pulled high
        tick(2);
        chk("rst_in",   gpio_in,   4'h0);
        chk("rst_rise", gpio_rise, 4'h0);
        chk("rst_fall", gpio_fall, 4'h0);
        gpio_oe[3] = 1'b1;
        #1;
        chk("rst_pad_drive", io_gpio, 4'b0111);
        gpio_oe[3] = 1'b0;
        #1;
        rst_n = 1'b1;
        tick(1);
        chk("rel_e1", gpio_in, 4'h0);
        tick(1);
        chk("rel_e2", gpio_in, 4'h0);
        tick(1);
        chk("rel_e3_in",   gpio_in,   4'hF);
        chk("rel_e3_rise", gpio_rise, ep(4'hF));
        tick(1);
        chk("rel_e4_rise", gpio_rise, 4'h0);

        // Pin 0 filtered (thresh 3), others bypassed; pads fall
        filt_en     = 4'b0001;
        filt_thresh = 4'd3;
        tb_en       = '1;
        tb_val      = '0;
        tick(2);
        chk("mix_e2", gpio_in, 4'hF);
        tick(1);
        chk("mix_e3_in",   gpio_in,   4'b0001);
        chk("mix_e3_fall", gpio_fall, ep(4'b1110));
        tick(2);
        chk("mix_e5_in",   gpio_in,   4'b0001);
        chk("mix_e5_fall", gpio_fall, 4'h0);
        tick(1);
        chk("mix_e6_in",   gpio_in,   4'h0);
        chk("mix_e6_fall", gpio_fall, ep(4'b0001));
        tick(1);
        chk("mix_e7_fall", gpio_fall, 4'h0);

        // 3-cycle glitch against thresh 3 must be rejected on all pins
        filt_en = '1;
        tb_val  = '1;
        acc_in  = '0;
        acc_p   = '0;
        for (int i = 0; i < 13; i++) begin
            tick(1);
            acc_in = acc_in | gpio_in;
            acc_p  = acc_p | gpio_rise | gpio_fall;
            if (i == 2) tb_val = '0;
        end
        chk("glitch_in",    acc_in, 4'h0);
        chk("glitch_pulse", acc_p,  4'h0);

        // Held high: flips on the 6th edge
        tb_val = '1;
        tick(5);
        chk("hold_e5", gpio_in, 4'h0);
        tick(1);
        chk("hold_e6_in",   gpio_in,   4'hF);
        chk("hold_e6_rise", gpio_rise, ep(4'hF));
        tick(1);
        chk("hold_e7_rise", gpio_rise, 4'h0);

        // Filter on with thresh 0 behaves like bypass
        filt_thresh = 4'd0;
        tb_val      = '0;
        tick(2);
        chk("th0_e2", gpio_in, 4'hF);
        tick(1);
        chk("th0_e3_in",   gpio_in,   4'h0);
        chk("th0_e3_fall", gpio_fall, ep(4'hF));

        // Bypass toggle 1 -> 0
        filt_en = '0;
        tb_val  = '1;
        tick(4);
        chk("byp_high", gpio_in, 4'hF);
        tb_val = '0;
        tick(2);
        chk("byp_e2", gpio_in, 4'hF);
        tick(1);
        chk("byp_e3_in",   gpio_in,   4'h0);
        chk("byp_e3_fall", gpio_fall, ep(4'hF));
        chk("byp_e3_rise", gpio_rise, 4'h0);
        tick(1);
        chk("byp_e4_fall", gpio_fall, 4'h0);

        // Threshold lowered mid-count: cnt=2 meets new thresh 1 next edge
        filt_en     = '1;
        filt_thresh = 4'd15;
        tb_val      = '1;
        tick(4);
        chk("mid_e4", gpio_in, 4'h0);
        filt_thresh = 4'd1;
        tick(1);
        chk("mid_e5_in",   gpio_in,   4'hF);
        chk("mid_e5_rise", gpio_rise, ep(4'hF));

        // Reset asserted while the filter is counting
        filt_thresh = 4'd15;
        tb_val      = '0;
        tick(6);
        chk("rmid_pre", gpio_in, 4'hF);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rmid_in",   gpio_in,   4'h0);
        chk("rmid_fall", gpio_fall, 4'h0);
        tick(1);
        rst_n  = 1'b1;
        acc_in = '0;
        acc_p  = '0;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            acc_in = acc_in | gpio_in;
            acc_p  = acc_p | gpio_rise | gpio_fall;
        end
        chk("rmid_post_in",    acc_in, 4'h0);
        chk("rmid_post_pulse", acc_p,  4'h0);

        // Input disabled: pulls decide, pad ignored
        filt_en     = '0;
        filt_thresh = 4'd0;
        gpio_ie     = '0;
        gpio_pu     = '1;
        tb_val      = '0;
        tick(3);
        chk("ie0_pu", gpio_in, 4'hF);
        gpio_pu = '0;
        gpio_pd = '1;
        tb_val  = '1;
        tick(3);
        chk("ie0_pd", gpio_in, 4'h0);
        gpio_pu = 4'b0101;
        tick(3);
        chk("ie0_mixed", gpio_in, 4'b0101);

        // Output drive / open-drain with the weak pull-up
        tb_en    = '0;
        gpio_oe  = '1;
        gpio_od  = '1;
        gpio_out = '1;
        #1;
        chk("od_out1", io_gpio, 4'hF);
        gpio_out = '0;
        #1;
        chk("od_out0", io_gpio, 4'h0);
        gpio_od  = '0;
        gpio_out = '1;
        #1;
        chk("pp_out1", io_gpio, 4'hF);
        gpio_od  = 4'b0101;
        gpio_out = 4'b0011;
        #1;
        chk("od_mixed", io_gpio, 4'b0011);
        gpio_oe = '0;
        #1;
        chk("oe0_pullup", io_gpio, 4'hF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
